// File: rtl/serial_word_packer_if.sv
// Handshake bundle for the serial word packer: a 1-bit upstream stream
// with flush, and a WIDTH-bit word + parity downstream.
interface serial_word_packer_if #(
    parameter int WIDTH = 8
);
    logic             up_valid;
    logic             up_data;
    logic             up_ready;
    logic             flush;
    logic             down_valid;
    logic [WIDTH-1:0] down_data;
    logic             down_parity;
    logic             down_ready;

    // Driver side: supplies bits and flush, consumes words.
    modport master (
        output up_valid, up_data, flush, down_ready,
        input  up_ready, down_valid, down_data, down_parity
    );

    // Packer side.
    modport slave (
        input  up_valid, up_data, flush, down_ready,
        output up_ready, down_valid, down_data, down_parity
    );
endinterface

// File: rtl/serial_word_packer.sv
// Serial-to-parallel packer: collects WIDTH accepted bits into a word and
// holds the finished word (with even parity) in an output register while
// the next word shifts in. Only the final bit of a word can stall.
module serial_word_packer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_word_packer_if.slave  bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] out_data;
    logic             out_par;
    logic             out_full;

    logic             last;
    logic             acc;
    logic             pop;
    logic             done;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] word_nxt;

    assign last = (cnt == LAST);
    // Stall only on the final bit when the held word cannot leave this cycle.
    assign bus.up_ready = !bus.flush && (!last || !out_full || bus.down_ready);
    assign acc  = bus.up_valid && bus.up_ready;
    assign pop  = out_full && bus.down_ready;
    assign done = acc && last;

    assign bus.down_valid  = out_full;
    assign bus.down_data   = out_data;
    assign bus.down_parity = out_par;

    // Shift register with the current bit inserted at its target position.
    always_comb begin
        idx      = (MSB_FIRST != 0) ? (LAST - cnt) : cnt;
        word_nxt = sr;
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) == idx) word_nxt[i] = bus.up_data;
        end
    end

    // Input side: bit counter and shift register; flush restarts the word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (acc) begin
            sr  <= word_nxt;
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

    // Output register: a completing word overwrites, otherwise a pop empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_par  <= 1'b0;
            out_full <= 1'b0;
        end else if (done) begin
            out_data <= word_nxt;
            out_par  <= ^word_nxt;
            out_full <= 1'b1;
        end else if (pop) begin
            out_full <= 1'b0;
        end
    end
endmodule
